// File: rtl/pla_pipe_eval.sv
// pla_pipe_eval: runtime-programmable PLA (AND/OR planes) evaluated in a two-stage valid/ready pipeline.
// Define PLA_OUTPUT_POLARITY_EN to add the writable output-inversion register.
module pla_pipe_eval #(
   parameter int NI = 41,
   parameter int NO = 21,
   parameter int NP = 64,
   parameter int PW = (NP > 1) ? $clog2(NP) : 1
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          cfg_we,
   input  logic [PW-1:0] cfg_p,
   input  logic [NI-1:0] cfg_tmask,
   input  logic [NI-1:0] cfg_cmask,
   input  logic [NO-1:0] cfg_omask,
   input  logic          cfg_pol_we,
   input  logic [NO-1:0] cfg_pol,
   output logic          cfg_ready,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [NI-1:0] in_data,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [NO-1:0] out_data,
   output logic [31:0]   eval_cnt
);
   logic [NI-1:0] tmask_q [NP];
   logic [NI-1:0] cmask_q [NP];
   logic [NO-1:0] omask_q [NP];
   logic [NO-1:0] pol;
   logic [NP-1:0] term_d, term_q;
   logic [NO-1:0] y_d, y_q;
   logic          s1_valid_q, s2_valid_q;
   logic          s1_load, s2_load, in_fire, cfg_wr;
   logic [31:0]   eval_cnt_q;

   // Config only lands on an empty pipe, so in-flight vectors never see a half-written PLA.
   assign cfg_ready = ~s1_valid_q & ~s2_valid_q;
   assign s2_load   = ~s2_valid_q | out_ready;
   assign s1_load   = ~s1_valid_q | s2_load;
   assign in_ready  = s1_load & ~cfg_wr;
   assign in_fire   = in_valid & in_ready;

`ifdef PLA_OUTPUT_POLARITY_EN
   logic [NO-1:0] pol_q;
   assign cfg_wr = cfg_ready & (cfg_we | cfg_pol_we);
   assign pol    = pol_q;
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) pol_q <= '0;
      else if (cfg_ready && cfg_pol_we) pol_q <= cfg_pol;
`else
   logic unused_pol;
   assign cfg_wr     = cfg_ready & cfg_we;
   assign pol        = '0;
   assign unused_pol = ^{cfg_pol_we, cfg_pol};
`endif

   for (genvar p = 0; p < NP; p++) begin : g_row
      // Rows only exist below NP, so an out-of-range cfg_p matches nothing.
      always_ff @(posedge clk or negedge rst_n)
         if (!rst_n) begin
            tmask_q[p] <= '0;
            cmask_q[p] <= '0;
            omask_q[p] <= '0;
         end else if (cfg_ready && cfg_we && cfg_p == PW'(p)) begin
            tmask_q[p] <= cfg_tmask;
            cmask_q[p] <= cfg_cmask;
            omask_q[p] <= cfg_omask;
         end
      assign term_d[p] = &((~tmask_q[p] | in_data) & (~cmask_q[p] | ~in_data));
   end

   always_comb begin
      y_d = '0;
      for (int p = 0; p < NP; p++) y_d = y_d | (omask_q[p] & {NO{term_q[p]}});
      y_d = y_d ^ pol;
   end

   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         s1_valid_q <= 1'b0;
         s2_valid_q <= 1'b0;
         term_q     <= '0;
         y_q        <= '0;
         eval_cnt_q <= '0;
      end else begin
         if (s1_load) s1_valid_q <= in_fire;
         if (in_fire) term_q <= term_d;
         if (s2_load) s2_valid_q <= s1_valid_q;
         if (s2_load && s1_valid_q) y_q <= y_d;
         if (out_valid && out_ready) eval_cnt_q <= eval_cnt_q + 32'd1;
      end

   assign out_valid = s2_valid_q;
   assign out_data  = y_q;
   assign eval_cnt  = eval_cnt_q;
endmodule

// File: tb/tb_pla_pipe_eval.sv
// tb_pla_pipe_eval: directed vectors with a queue scoreboard drained by a negedge monitor.
module tb_pla_pipe_eval;
   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       cfg_we = 1'b0;
   logic [1:0] cfg_p = '0;
   logic [3:0] cfg_tmask = '0, cfg_cmask = '0;
   logic [1:0] cfg_omask = '0;
   logic       cfg_pol_we = 1'b0;
   logic [1:0] cfg_pol = '0;
   logic       cfg_ready;
   logic       in_valid = 1'b0;
   logic       in_ready;
   logic [3:0] in_data = '0;
   logic       out_valid;
   logic       out_ready = 1'b1;
   logic [1:0] out_data;
   logic [31:0] eval_cnt;

   int checks = 0;
   int errors = 0;
   logic [1:0] sb[$];
   logic       held = 1'b0;
   logic [1:0] held_data = '0;
   logic       saw_stall = 1'b0;

   pla_pipe_eval #(.NI(4), .NO(2), .NP(4)) dut (
      .clk(clk), .rst_n(rst_n),
      .cfg_we(cfg_we), .cfg_p(cfg_p), .cfg_tmask(cfg_tmask), .cfg_cmask(cfg_cmask),
      .cfg_omask(cfg_omask), .cfg_pol_we(cfg_pol_we), .cfg_pol(cfg_pol), .cfg_ready(cfg_ready),
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .eval_cnt(eval_cnt)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   always @(negedge clk) begin
      if (!rst_n) held = 1'b0;
      else begin
         if (held) begin
            chk("stall_valid", {31'd0, out_valid}, 32'd1);
            chk("stall_data", {30'd0, out_data}, {30'd0, held_data});
         end
         if (in_valid && !in_ready) saw_stall = 1'b1;
         if (out_valid && out_ready) begin
            if (sb.size() == 0) chk("unexpected_out", {30'd0, out_data}, 32'hFFFF_FFFF);
            else chk("out_data", {30'd0, out_data}, {30'd0, sb.pop_front()});
         end
         held = out_valid & ~out_ready;
         held_data = out_data;
      end
   end

   task automatic do_reset();
      rst_n = 1'b0; in_valid = 1'b0; cfg_we = 1'b0; cfg_pol_we = 1'b0; out_ready = 1'b1;
      #1;
      sb.delete();
      chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
      chk("rst_out_data", {30'd0, out_data}, 32'd0);
      chk("rst_eval_cnt", eval_cnt, 32'd0);
      chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
      chk("rst_cfg_ready", {31'd0, cfg_ready}, 32'd1);
      @(negedge clk) rst_n = 1'b1;
      @(posedge clk); #1;
   endtask

   task automatic send(input logic [3:0] x, input logic [1:0] e);
      int n = 0;
      logic ok = 1'b0;
      sb.push_back(e);
      in_valid = 1'b1; in_data = x;
      do begin
         @(negedge clk) ok = in_ready;
         @(posedge clk); #1;
         n++;
      end while (!ok && n < 100);
      if (!ok) chk("send_timeout", 32'd0, 32'd1);
   endtask

   task automatic drain();
      int n = 0;
      do begin
         @(posedge clk); #1;
         n++;
      end while (!(sb.size() == 0 && !out_valid) && n < 100);
      if (n >= 100) chk("drain_timeout", 32'd0, 32'd1);
   endtask

   task automatic wr_term(input logic [1:0] p, input logic [3:0] t, input logic [3:0] c, input logic [1:0] o);
      cfg_we = 1'b1; cfg_p = p; cfg_tmask = t; cfg_cmask = c; cfg_omask = o;
      @(negedge clk) chk("cfg_ready_idle", {31'd0, cfg_ready}, 32'd1);
      @(posedge clk); #1;
      cfg_we = 1'b0;
   endtask

   initial begin
      repeat (2) @(posedge clk);
      #1;
      do_reset();
      // unconfigured PLA, latency measured from presentation
      sb.push_back(2'b00);
      in_valid = 1'b1; in_data = 4'hF;
      @(negedge clk) chk("lat_in_ready", {31'd0, in_ready}, 32'd1);
      @(posedge clk); #1;
      in_valid = 1'b0;
      chk("lat_edge1", {31'd0, out_valid}, 32'd0);
      @(posedge clk); #1;
      chk("lat_edge2", {31'd0, out_valid}, 32'd1);
      send(4'h0, 2'b00);
      in_valid = 1'b0;
      drain();
      chk("eval_cnt_2", eval_cnt, 32'd2);
      // basic SOP
      wr_term(2'd0, 4'b0011, 4'b0000, 2'b01);
      wr_term(2'd1, 4'b0000, 4'b1000, 2'b10);
      send(4'b0011, 2'b11);
      send(4'b1011, 2'b01);
      send(4'b1000, 2'b00);
      in_valid = 1'b0;
      drain();
      chk("eval_cnt_5", eval_cnt, 32'd5);
      // contradictory term and empty term
      do_reset();
      wr_term(2'd0, 4'b0001, 4'b0001, 2'b11);
      send(4'b0000, 2'b00);
      send(4'b0001, 2'b00);
      send(4'b1111, 2'b00);
      in_valid = 1'b0;
      drain();
      wr_term(2'd1, 4'b0000, 4'b0000, 2'b10);
      send(4'b0000, 2'b10);
      send(4'b0101, 2'b10);
      in_valid = 1'b0;
      drain();
      // backpressure burst, y = x[1:0]
      do_reset();
      wr_term(2'd0, 4'b0001, 4'b0000, 2'b01);
      wr_term(2'd1, 4'b0010, 4'b0000, 2'b10);
      saw_stall = 1'b0;
      fork
         begin
            for (int i = 0; i < 8; i++) begin
               logic [3:0] x;
               x = 4'(i);
               send(x, x[1:0]);
            end
            in_valid = 1'b0;
         end
         begin
            repeat (2) @(posedge clk);
            #1 out_ready = 1'b0;
            repeat (5) @(posedge clk);
            #1 out_ready = 1'b1;
         end
      join
      drain();
      chk("burst_count", eval_cnt, 32'd8);
      chk("burst_in_ready_low", {31'd0, saw_stall}, 32'd1);
      // config collides with a vector on an empty pipe
      cfg_we = 1'b1; cfg_p = 2'd2; cfg_tmask = 4'b0100; cfg_cmask = 4'b0000; cfg_omask = 2'b01;
      in_valid = 1'b1; in_data = 4'b0100;
      sb.push_back(2'b01);
      @(negedge clk);
      chk("collide_in_ready", {31'd0, in_ready}, 32'd0);
      chk("collide_cfg_ready", {31'd0, cfg_ready}, 32'd1);
      @(posedge clk); #1;
      cfg_we = 1'b0;
      void'(sb.pop_back());
      send(4'b0100, 2'b01);
      in_valid = 1'b0;
      drain();
      // config while busy is dropped
      out_ready = 1'b0;
      send(4'b0000, 2'b00);
      in_valid = 1'b0;
      cfg_we = 1'b1; cfg_p = 2'd3; cfg_tmask = 4'b0000; cfg_cmask = 4'b0000; cfg_omask = 2'b11;
      @(negedge clk) chk("busy_cfg_ready", {31'd0, cfg_ready}, 32'd0);
      @(posedge clk); #1;
      cfg_we = 1'b0;
      out_ready = 1'b1;
      drain();
      send(4'b0000, 2'b00);
      in_valid = 1'b0;
      drain();
      // output polarity
      do_reset();
      cfg_pol_we = 1'b1; cfg_pol = 2'b10;
      @(posedge clk); #1;
      cfg_pol_we = 1'b0;
`ifdef PLA_OUTPUT_POLARITY_EN
      send(4'b0000, 2'b10);
      send(4'b1111, 2'b10);
`else
      send(4'b0000, 2'b00);
      send(4'b1111, 2'b00);
`endif
      in_valid = 1'b0;
      drain();
      // reset mid-burst
      do_reset();
      wr_term(2'd1, 4'b0000, 4'b0000, 2'b10);
      out_ready = 1'b0;
      send(4'b0001, 2'b10);
      send(4'b0010, 2'b10);
      #2 rst_n = 1'b0;
      #1;
      chk("midrst_out_valid", {31'd0, out_valid}, 32'd0);
      chk("midrst_eval_cnt", eval_cnt, 32'd0);
      do_reset();
      send(4'b0000, 2'b00);
      in_valid = 1'b0;
      drain();
      chk("midrst_cnt_after", eval_cnt, 32'd1);
      chk("sb_empty", sb.size(), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end
endmodule
